// File: rtl/fp_vector_result_collector.sv
// Collects 4-lane FP12 result vectors from a fixed-latency, valid-only adder into a FIFO,
// presents them over ready/valid and returns issue credits so the FIFO can never be oversubscribed.
module fp_vector_result_collector #(
    parameter int EXP_BITS  = 5,
    parameter int MANT_BITS = 6,
    parameter int LANES     = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       issue_valid,
    output logic                                       issue_allow,
    input  logic                                       res_valid,
    input  logic [EXP_BITS+MANT_BITS:0]                res_a,
    input  logic [EXP_BITS+MANT_BITS:0]                res_b,
    input  logic [EXP_BITS+MANT_BITS:0]                res_c,
    input  logic [EXP_BITS+MANT_BITS:0]                res_d,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [LANES*(EXP_BITS+MANT_BITS+1)-1:0]    m_data,
    output logic [CNT_BITS-1:0]                        m_count,
    output logic                                       full,
    output logic                                       empty,
    output logic [1:0]                                 err
);
    localparam int W        = EXP_BITS + MANT_BITS + 1;
    localparam int VEC_W    = LANES * W;
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

    logic [VEC_W-1:0]    mem_q [DEPTH];
    logic [CNT_BITS-1:0] occ_q, occ_d;
    logic [CNT_BITS-1:0] inflight_q, inflight_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]          err_q, err_d;
    logic                push, pop, drop, viol;

    // Credit check uses registered state only, so there is no path from issue/res inputs.
    assign issue_allow = ({1'b0, occ_q} + {1'b0, inflight_q}) < {1'b0, DEPTH_C};

    assign m_valid = (occ_q != '0);
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_count = occ_q;
    assign full    = (occ_q == DEPTH_C);
    assign empty   = (occ_q == '0);
    assign err     = err_q;

    always_comb begin
        pop        = m_valid && m_ready;
        // A full FIFO still accepts a vector when the head leaves in the same cycle.
        push       = res_valid && ((occ_q != DEPTH_C) || pop);
        drop       = res_valid && !push;
        viol       = (issue_valid && !issue_allow) || (res_valid && (inflight_q == '0));
        occ_d      = occ_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q | {viol, drop};

        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (issue_valid && !res_valid) begin
            if (inflight_q != DEPTH_C) begin
                inflight_d = inflight_q + 1'b1;
            end
        end else if (res_valid && !issue_valid) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            inflight_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_a, res_b, res_c, res_d};
        end
    end
endmodule

// File: tb/tb_fp_vector_result_collector.sv
// Directed bench for fp_vector_result_collector: credit loop, FIFO order across wraps,
// full push/pop, overflow, protocol violations and mid-operation reset.
module tb_fp_vector_result_collector;
    logic        clk = 1'b0;
    logic        rst, issue_valid, issue_allow, res_valid, m_valid, m_ready, full, empty;
    logic [11:0] res_a, res_b, res_c, res_d;
    logic [47:0] m_data;
    logic [3:0]  m_count;
    logic [1:0]  err;
    int checks = 0;
    int errors = 0;

    fp_vector_result_collector dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_allow(issue_allow),
        .res_valid(res_valid), .res_a(res_a), .res_b(res_b), .res_c(res_c), .res_d(res_d),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] vec(input logic [11:0] d);
        return {12'h3C0, 12'h400, 12'hBC0, d};
    endfunction

    // 8 issues back to back, each result 2 cycles later with lane d = index.
    task automatic fill(input bit chk_err);
        for (int t = 0; t < 10; t++) begin
            issue_valid = (t < 8);
            res_valid   = (t >= 2);
            res_a = 12'h3C0; res_b = 12'h400; res_c = 12'hBC0;
            res_d = (t >= 2) ? 12'(t - 2) : 12'h000;
            tick();
            chk("fill_allow", issue_allow, (t < 7));
            chk("fill_count", m_count, (t >= 2) ? t - 1 : 0);
        end
        issue_valid = 1'b0; res_valid = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_count8", m_count, 8);
        if (chk_err) chk("fill_err", err, 0);
    endtask

    task automatic drain(input int first_k, input bit has_tail, input logic [11:0] tail_d);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", m_valid, 1);
            if (has_tail && i == 7) chk("drain_tail", m_data, vec(tail_d));
            else chk("drain_data", m_data, vec(12'(first_k + i)));
            tick();
        end
        m_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_mvalid", m_valid, 0);
        chk("drain_allow", issue_allow, 1);
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; res_valid = 1'b0; m_ready = 1'b0;
        res_a = '0; res_b = '0; res_c = '0; res_d = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", m_count, 0);
        chk("rst_allow", issue_allow, 1);
        chk("rst_err", err, 0);
        chk("rst_mdata", m_data, 0);

        // Three fill/drain rounds walk the pointers around the ring.
        for (int r = 0; r < 3; r++) begin
            fill(1'b1);
            drain(0, 1'b0, 12'h000);
        end
        chk("wrap_err", err, 0);

        // Push and pop together while full; the new vector becomes the tail.
        fill(1'b1);
        res_valid = 1'b1; m_ready = 1'b1;
        res_a = 12'h3C0; res_b = 12'h400; res_c = 12'hBC0; res_d = 12'h0AA;
        tick();
        res_valid = 1'b0; m_ready = 1'b0;
        chk("pp_count", m_count, 8);
        chk("pp_err0", err[0], 0);
        chk("pp_head", m_data, vec(12'h001));
        drain(1, 1'b1, 12'h0AA);

        // Overflow drops the vector and sticks err[0].
        fill(1'b0);
        res_valid = 1'b1; res_a = 12'h7FF; res_d = 12'h055;
        tick();
        res_valid = 1'b0;
        chk("ovf_count", m_count, 8);
        chk("ovf_err0", err[0], 1);
        drain(0, 1'b0, 12'h000);
        chk("ovf_sticky", err[0], 1);

        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_err", err, 0);

        // Eight issues with no results exhaust credits, then one more violates.
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("cred_allow", issue_allow, 0);
        chk("cred_err_pre", err, 0);
        tick();
        issue_valid = 1'b0;
        chk("cred_err", err, 2'b10);

        rst = 1'b1; tick(); rst = 1'b0;
        // Build occupancy 5 with 2 still in flight, then reset mid-operation.
        res_a = 12'h3C0; res_b = 12'h400; res_c = 12'hBC0;
        for (int t = 0; t < 7; t++) begin
            issue_valid = 1'b1;
            res_valid   = (t >= 2);
            res_d       = 12'(t);
            tick();
        end
        issue_valid = 1'b0; res_valid = 1'b0;
        chk("mid_count", m_count, 5);
        chk("mid_allow", issue_allow, 1);
        chk("mid_err", err, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_count", m_count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_mvalid", m_valid, 0);
        chk("mid_rst_mdata", m_data, 0);
        chk("mid_rst_allow", issue_allow, 1);
        chk("mid_rst_err", err, 0);

        // Late result after reset is unsolicited but still stored.
        res_valid = 1'b1; res_d = 12'h123;
        tick();
        res_valid = 1'b0;
        chk("late_count", m_count, 1);
        chk("late_err", err, 2'b10);
        chk("late_data", m_data, vec(12'h123));
        chk("late_allow", issue_allow, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
